// File: rtl/program_loader_pkg.sv
// Shared types and default instruction images for the program loader.
// Boards that need different programs override IMAGE_TABLE / LEN_TABLE on the top.
package loader_pkg;

    localparam int DEF_INSTR_W      = 16;
    localparam int DEF_MAX_LEN      = 16;
    localparam int DEF_NUM_PROGRAMS = 3;
    localparam int DEF_LEN_W        = $clog2(DEF_MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WRITE,
        RELEASE
    } state_t;

    typedef logic [DEF_NUM_PROGRAMS-1:0][DEF_MAX_LEN-1:0][DEF_INSTR_W-1:0] image_t;
    typedef logic [DEF_NUM_PROGRAMS-1:0][DEF_LEN_W-1:0] len_table_t;

    // Program 0 is the LED chaser, 1 a short counter, 2 a fixed bit pattern.
    function automatic image_t build_default_image();
        image_t img;
        img = '0;
        img[0][0]  = 16'h2021;
        img[0][1]  = 16'h0022;
        img[0][2]  = 16'h0023;
        img[0][3]  = 16'h202b;
        img[0][4]  = 16'hfad0;
        img[0][5]  = 16'h5200;
        img[0][6]  = 16'h102b;
        img[0][7]  = 16'h00da;
        img[0][8]  = 16'h0132;
        img[0][9]  = 16'h0133;
        img[0][10] = 16'h0a60;
        img[0][11] = 16'hf6e7;
        img[0][12] = 16'hfee7;
        img[1][0]  = 16'h2001;
        img[1][1]  = 16'h3011;
        img[1][2]  = 16'h0a60;
        img[1][3]  = 16'h2111;
        img[1][4]  = 16'h0a61;
        img[1][5]  = 16'hf8e7;
        img[1][6]  = 16'hfee7;
        img[2][0]  = 16'h00ff;
        img[2][1]  = 16'hff00;
        img[2][2]  = 16'h0f0f;
        img[2][3]  = 16'hf0f0;
        img[2][4]  = 16'h3333;
        img[2][5]  = 16'hcccc;
        img[2][6]  = 16'h5555;
        img[2][7]  = 16'haaaa;
        return img;
    endfunction

    localparam image_t DEFAULT_IMAGE = build_default_image();

    localparam len_table_t DEFAULT_LEN = {
        DEF_LEN_W'(8),
        DEF_LEN_W'(7),
        DEF_LEN_W'(13)
    };

endpackage

// File: rtl/program_loader_if.sv
// Selection inputs, CPU instruction-memory write port and status of the loader.
interface program_loader_if #(
    parameter int SEL_W   = 8,
    parameter int IDX_W   = 8,
    parameter int INSTR_W = 16
);

    logic [SEL_W-1:0]   select;
    logic               load;
    logic               cpu_reset;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_index;
    logic [INSTR_W-1:0] wr_data;
    logic               busy;
    logic               done;
    logic               error;
    logic [SEL_W-1:0]   loaded;
    logic               loaded_valid;

    modport master (
        input  select,
        input  load,
        output cpu_reset,
        output wr_en,
        output wr_index,
        output wr_data,
        output busy,
        output done,
        output error,
        output loaded,
        output loaded_valid
    );

    modport slave (
        output select,
        output load,
        input  cpu_reset,
        input  wr_en,
        input  wr_index,
        input  wr_data,
        input  busy,
        input  done,
        input  error,
        input  loaded,
        input  loaded_valid
    );

endinterface

// File: rtl/program_loader_rom.sv
// Combinational image lookup: (program, word number) -> (instruction word, program length).
// Out-of-range program or word numbers read as zero.
module program_rom
    import loader_pkg::*;
#(
    parameter int INSTR_W      = 16,
    parameter int SEL_W        = 8,
    parameter int NUM_PROGRAMS = 3,
    parameter int MAX_LEN      = 16,
    parameter logic [NUM_PROGRAMS-1:0][MAX_LEN-1:0][INSTR_W-1:0] IMAGE_TABLE = DEFAULT_IMAGE,
    parameter logic [NUM_PROGRAMS-1:0][$clog2(MAX_LEN+1)-1:0]    LEN_TABLE   = DEFAULT_LEN
) (
    input  logic [SEL_W-1:0]             prog,
    input  logic [$clog2(MAX_LEN+1)-1:0] k,
    output logic [INSTR_W-1:0]           word,
    output logic [$clog2(MAX_LEN+1)-1:0] len
);

    localparam int KW = $clog2(MAX_LEN + 1);

    always_comb begin
        word = '0;
        len  = '0;
        for (int p = 0; p < NUM_PROGRAMS; p++) begin
            if (prog == SEL_W'(p)) begin
                len = LEN_TABLE[p];
                for (int w = 0; w < MAX_LEN; w++) begin
                    if (k == KW'(w)) begin
                        word = IMAGE_TABLE[p][w];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Copies a selected instruction image into CPU instruction memory while holding the CPU in reset.
// All outputs are registered; the next-state logic computes their next values one cycle ahead.
module program_loader
    import loader_pkg::*;
#(
    parameter int INSTR_W      = 16,
    parameter int IDX_W        = 8,
    parameter int SEL_W        = 8,
    parameter int NUM_PROGRAMS = 3,
    parameter int MAX_LEN      = 16,
    parameter int BASE_INDEX   = 10,
    parameter int AUTO_RELOAD  = 1,
    parameter logic [NUM_PROGRAMS-1:0][MAX_LEN-1:0][INSTR_W-1:0] IMAGE_TABLE = DEFAULT_IMAGE,
    parameter logic [NUM_PROGRAMS-1:0][$clog2(MAX_LEN+1)-1:0]    LEN_TABLE   = DEFAULT_LEN
) (
    input logic              clk,
    input logic              reset,
    program_loader_if.master bus
);

    localparam int KW = $clog2(MAX_LEN + 1);

    if (BASE_INDEX + MAX_LEN > (1 << IDX_W)) begin : g_index_range_check
        $error("program_loader: BASE_INDEX + MAX_LEN exceeds the instruction index range");
    end

    for (genvar i = 0; i < NUM_PROGRAMS; i++) begin : g_len_check
        if (int'(LEN_TABLE[i]) > MAX_LEN) begin : g_len_too_long
            $error("program_loader: LEN_TABLE entry exceeds MAX_LEN");
        end
    end

    state_t             state, state_next;
    logic [SEL_W-1:0]   prog, prog_next;
    logic [KW-1:0]      k, k_next;
    logic [KW-1:0]      len_q, len_next;
    logic [SEL_W-1:0]   sel_prev;
    logic               err_armed, err_armed_next;

    logic               cpu_reset, cpu_reset_next;
    logic               wr_en, wr_en_next;
    logic [IDX_W-1:0]   wr_index, wr_index_next;
    logic [INSTR_W-1:0] wr_data, wr_data_next;
    logic               busy, busy_next;
    logic               done, done_next;
    logic               error, error_next;
    logic [SEL_W-1:0]   loaded, loaded_next;
    logic               loaded_valid, loaded_valid_next;

    logic [INSTR_W-1:0] rom_word;
    logic [KW-1:0]      rom_len;
    logic               sel_valid;
    logic               sel_changed;
    logic               mismatch;
    logic               armed_now;

    program_rom #(
        .INSTR_W      (INSTR_W),
        .SEL_W        (SEL_W),
        .NUM_PROGRAMS (NUM_PROGRAMS),
        .MAX_LEN      (MAX_LEN),
        .IMAGE_TABLE  (IMAGE_TABLE),
        .LEN_TABLE    (LEN_TABLE)
    ) rom (
        .prog (prog),
        .k    (k),
        .word (rom_word),
        .len  (rom_len)
    );

    assign sel_valid   = ({1'b0, bus.select} < (SEL_W + 1)'(NUM_PROGRAMS));
    assign sel_changed = (bus.select != sel_prev);
    assign mismatch    = (AUTO_RELOAD != 0) && (!loaded_valid || (bus.select != loaded));
    // An invalid auto-mismatch reports once, and again only after select moves.
    assign armed_now   = err_armed || sel_changed;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prog         <= '0;
            k            <= '0;
            len_q        <= '0;
            sel_prev     <= '0;
            err_armed    <= 1'b1;
            cpu_reset    <= 1'b0;
            wr_en        <= 1'b0;
            wr_index     <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            loaded       <= '0;
            loaded_valid <= 1'b0;
        end else begin
            state        <= state_next;
            prog         <= prog_next;
            k            <= k_next;
            len_q        <= len_next;
            sel_prev     <= bus.select;
            err_armed    <= err_armed_next;
            cpu_reset    <= cpu_reset_next;
            wr_en        <= wr_en_next;
            wr_index     <= wr_index_next;
            wr_data      <= wr_data_next;
            busy         <= busy_next;
            done         <= done_next;
            error        <= error_next;
            loaded       <= loaded_next;
            loaded_valid <= loaded_valid_next;
        end
    end

    always_comb begin
        state_next        = state;
        prog_next         = prog;
        k_next            = k;
        len_next          = len_q;
        err_armed_next    = armed_now;
        cpu_reset_next    = cpu_reset;
        wr_en_next        = 1'b0;
        wr_index_next     = '0;
        wr_data_next      = '0;
        busy_next         = busy;
        done_next         = 1'b0;
        error_next        = 1'b0;
        loaded_next       = loaded;
        loaded_valid_next = loaded_valid;

        case (state)
            IDLE: begin
                cpu_reset_next = 1'b0;
                busy_next      = 1'b0;
                k_next         = '0;
                if (bus.load || mismatch) begin
                    if (sel_valid) begin
                        prog_next      = bus.select;
                        state_next     = ASSERT;
                        cpu_reset_next = 1'b1;
                        busy_next      = 1'b1;
                    end else begin
                        if (bus.load || armed_now) begin
                            error_next = 1'b1;
                        end
                        if (mismatch) begin
                            err_armed_next = 1'b0;
                        end
                    end
                end
            end

            ASSERT: begin
                len_next = rom_len;
                if (rom_len != '0) begin
                    wr_en_next    = 1'b1;
                    wr_index_next = IDX_W'(BASE_INDEX) + IDX_W'(k);
                    wr_data_next  = rom_word;
                    k_next        = k + KW'(1);
                    state_next    = WRITE;
                end else begin
                    done_next         = 1'b1;
                    loaded_next       = prog;
                    loaded_valid_next = 1'b1;
                    state_next        = RELEASE;
                end
            end

            WRITE: begin
                if (k == len_q) begin
                    done_next         = 1'b1;
                    loaded_next       = prog;
                    loaded_valid_next = 1'b1;
                    state_next        = RELEASE;
                end else begin
                    wr_en_next    = 1'b1;
                    wr_index_next = IDX_W'(BASE_INDEX) + IDX_W'(k);
                    wr_data_next  = rom_word;
                    k_next        = k + KW'(1);
                end
            end

            RELEASE: begin
                cpu_reset_next = 1'b0;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cpu_reset    = cpu_reset;
    assign bus.wr_en        = wr_en;
    assign bus.wr_index     = wr_index;
    assign bus.wr_data      = wr_data;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.error        = error;
    assign bus.loaded       = loaded;
    assign bus.loaded_valid = loaded_valid;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench: an auto-reload loader with the stock images and a manual-load loader
// whose extra program 3 is empty.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    program_loader_if bus_a ();
    program_loader_if bus_b ();

    localparam logic [3:0][15:0][15:0] B_IMAGE = {256'h0, loader_pkg::DEFAULT_IMAGE};
    localparam logic [3:0][4:0]        B_LEN   = {5'd0, loader_pkg::DEFAULT_LEN};

    program_loader #(
        .AUTO_RELOAD (1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    program_loader #(
        .AUTO_RELOAD  (0),
        .NUM_PROGRAMS (4),
        .IMAGE_TABLE  (B_IMAGE),
        .LEN_TABLE    (B_LEN)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    localparam logic [0:12][15:0] CHASER = {
        16'h2021, 16'h0022, 16'h0023, 16'h202b, 16'hfad0, 16'h5200, 16'h102b,
        16'h00da, 16'h0132, 16'h0133, 16'h0a60, 16'hf6e7, 16'hfee7
    };
    localparam logic [0:6][15:0] COUNTUP = {
        16'h2001, 16'h3011, 16'h0a60, 16'h2111, 16'h0a61, 16'hf8e7, 16'hfee7
    };
    localparam logic [0:7][15:0] PATTERN = {
        16'h00ff, 16'hff00, 16'h0f0f, 16'hf0f0, 16'h3333, 16'hcccc, 16'h5555, 16'haaaa
    };

    typedef struct packed {
        logic        cpu_reset;
        logic        busy;
        logic        wr_en;
        logic        done;
        logic        error;
        logic        loaded_valid;
        logic [7:0]  wr_index;
        logic [15:0] wr_data;
        logic [7:0]  loaded;
        logic [7:0]  select;
    } obs_t;

    int check_count = 0;
    int error_count = 0;

    function automatic logic [15:0] expectedWord(input int p, input int k);
        case (p)
            0:       return CHASER[4'(k)];
            1:       return COUNTUP[3'(k)];
            2:       return PATTERN[3'(k)];
            default: return 16'h0000;
        endcase
    endfunction

    function automatic obs_t sampleBus(input bit which);
        obs_t o;
        if (which) begin
            o = '{bus_b.cpu_reset, bus_b.busy, bus_b.wr_en, bus_b.done, bus_b.error,
                  bus_b.loaded_valid, bus_b.wr_index, bus_b.wr_data, bus_b.loaded, bus_b.select};
        end else begin
            o = '{bus_a.cpu_reset, bus_a.busy, bus_a.wr_en, bus_a.done, bus_a.error,
                  bus_a.loaded_valid, bus_a.wr_index, bus_a.wr_data, bus_a.loaded, bus_a.select};
        end
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit which, input logic [7:0] sel, input logic ld);
        if (which) begin
            bus_b.select = sel;
            bus_b.load   = ld;
        end else begin
            bus_a.select = sel;
            bus_a.load   = ld;
        end
    endtask

    task automatic checkResetValues(input string tag, input bit which);
        obs_t o;
        o = sampleBus(which);
        checkOutput({tag, ".flags"}, {26'd0, o.cpu_reset, o.busy, o.wr_en, o.done, o.error, o.loaded_valid}, 32'd0);
        checkOutput({tag, ".wr_index"}, {24'd0, o.wr_index}, 32'd0);
        checkOutput({tag, ".wr_data"}, {16'd0, o.wr_data}, 32'd0);
        checkOutput({tag, ".loaded"}, {24'd0, o.loaded}, 32'd0);
    endtask

    // Called on the negedge just before the edge that sees the trigger; checks every cycle after it.
    task automatic expectTransfer(input string tag, input bit which, input int prog, input int len,
                                  input int change_at, input logic [7:0] change_sel,
                                  input bit hold_load, input int reset_at);
        obs_t       o;
        int         writes;
        bit         aborted;
        logic [7:0] cur_sel;
        writes  = 0;
        aborted = 1'b0;
        for (int n = 1; n <= len + 3; n++) begin
            @(negedge clk);
            o = sampleBus(which);
            checkOutput($sformatf("%s.ctl@%0d", tag, n),
                        {28'd0, o.cpu_reset, o.busy, o.wr_en, o.done},
                        {28'd0, n <= len + 2, n <= len + 2, (n >= 2) && (n <= len + 1), n == len + 2});
            if (o.wr_en) writes++;
            if ((n >= 2) && (n <= len + 1)) begin
                checkOutput($sformatf("%s.idx@%0d", tag, n), {24'd0, o.wr_index}, 32'(10 + n - 2));
                checkOutput($sformatf("%s.data@%0d", tag, n), {16'd0, o.wr_data}, {16'd0, expectedWord(prog, n - 2)});
            end
            if (n == len + 3) begin
                checkOutput({tag, ".loaded"}, {23'd0, o.loaded_valid, o.loaded}, {23'd0, 1'b1, 8'(prog)});
            end
            cur_sel = o.select;
            if (n == change_at) cur_sel = change_sel;
            applyStimulus(which, cur_sel, hold_load);
            if (n == reset_at) begin
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) checkOutput({tag, ".writes_before_reset"}, writes, reset_at - 1);
        else         checkOutput({tag, ".writes"}, writes, len);
    endtask

    initial begin
        obs_t o;
        $display("[TB] starting program_loader bench");
        applyStimulus(1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("reset_a", 1'b0);
        checkResetValues("reset_b", 1'b1);

        // Auto-reload picks up select=0 right after reset.
        reset = 1'b0;
        expectTransfer("auto0", 1'b0, 0, 13, 0, 8'd0, 1'b0, 0);

        // Reload program 0 while select moves to 1 mid-transfer, then program 1 follows.
        applyStimulus(1'b0, 8'd0, 1'b1);
        expectTransfer("chg", 1'b0, 0, 13, 4, 8'd1, 1'b0, 0);
        expectTransfer("sel1", 1'b0, 1, 7, 0, 8'd0, 1'b0, 0);

        // Reset on the 4th write of program 2, then a full reload.
        applyStimulus(1'b0, 8'd2, 1'b0);
        expectTransfer("p2rst", 1'b0, 2, 8, 0, 8'd0, 1'b0, 5);
        @(negedge clk);
        checkResetValues("midreset_a", 1'b0);
        reset = 1'b0;
        expectTransfer("p2again", 1'b0, 2, 8, 0, 8'd0, 1'b0, 0);

        // Invalid select in auto mode reports only once.
        applyStimulus(1'b0, 8'd7, 1'b0);
        @(negedge clk);
        o = sampleBus(1'b0);
        checkOutput("auto_err.first", {30'd0, o.error, o.busy}, 32'b10);
        @(negedge clk);
        o = sampleBus(1'b0);
        checkOutput("auto_err.second", {30'd0, o.error, o.busy}, 32'b00);
        @(negedge clk);
        o = sampleBus(1'b0);
        checkOutput("auto_err.third", {30'd0, o.error, o.busy}, 32'b00);
        applyStimulus(1'b0, 8'd2, 1'b0);

        // Load held high through a transfer: one drop-all transfer plus one from IDLE.
        applyStimulus(1'b1, 8'd1, 1'b1);
        expectTransfer("hold", 1'b1, 1, 7, 0, 8'd0, 1'b1, 0);
        expectTransfer("again", 1'b1, 1, 7, 0, 8'd0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = sampleBus(1'b1);
            checkOutput($sformatf("quiet_b@%0d", i), {29'd0, o.busy, o.cpu_reset, o.wr_en}, 32'd0);
        end

        // Manual load of an out-of-range program.
        applyStimulus(1'b1, 8'd5, 1'b1);
        @(negedge clk);
        o = sampleBus(1'b1);
        checkOutput("err.flags", {28'd0, o.error, o.busy, o.wr_en, o.cpu_reset}, 32'b1000);
        checkOutput("err.loaded", {23'd0, o.loaded_valid, o.loaded}, {23'd0, 1'b1, 8'd1});
        applyStimulus(1'b1, 8'd5, 1'b0);
        @(negedge clk);
        o = sampleBus(1'b1);
        checkOutput("err.after", {28'd0, o.error, o.busy, o.wr_en, o.cpu_reset}, 32'd0);
        checkOutput("err.loaded_after", {23'd0, o.loaded_valid, o.loaded}, {23'd0, 1'b1, 8'd1});

        // Empty program: no writes, done two cycles after the trigger.
        applyStimulus(1'b1, 8'd3, 1'b1);
        expectTransfer("zero", 1'b1, 3, 0, 0, 8'd0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
